// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_if
// Purpose : Bundles the frame/response signals between the SPI slave and the
//           RAM endpoint so both sides share one connection object.
// Signals :
//   rx_data  [9:0]  frame from SPI slave: [9:8] command, [7:0] payload
//   rx_valid        rx_data carries a frame this cycle
//   tx_data  [7:0]  read data returned to the SPI slave
//   tx_valid        one-cycle pulse, tx_data holds fresh read data
//   cmd_err         one-cycle pulse, data command issued with no address loaded
// Modports:
//   master  - SPI slave side (drives frames, receives responses)
//   slave   - RAM endpoint side (spi_ram_ctrl)
// ---------------------------------------------------------------------------
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        input  cmd_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        output cmd_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Purpose : Single-port RAM endpoint downstream of the SPI slave. Each 10-bit
//           frame is decoded by its command field and either loads an
//           address register, writes memory, or reads memory back out.
// Ports   :
//   clk   in   single clock, all logic on posedge
//   rst   in   synchronous active-high reset
//   bus   slave modport of spi_ram_ctrl_if (rx_data/rx_valid in,
//         tx_data/tx_valid/cmd_err out)
// Parameters:
//   MEM_DEPTH  number of 8-bit words, must equal 2**ADDR_SIZE
//   ADDR_SIZE  address width, taken from the low bits of the payload
// Configuration macro:
//   SPI_RAM_AUTOINC_EN - when defined, successful WR_DATA / RD_DATA
//   post-increment their address register (wrapping MEM_DEPTH-1 -> 0).
// ---------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_ok_q,   wr_ok_d;
    logic                 rd_ok_q,   rd_ok_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 mem_we;

    cmd_e                 cmd;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] payload_addr;

    // Payload bits above ADDR_SIZE are dropped, so addresses wrap modulo
    // MEM_DEPTH.
    assign cmd          = cmd_e'(bus.rx_data[9:8]);
    assign payload      = bus.rx_data[7:0];
    assign payload_addr = ADDR_SIZE'(payload);

    // Command decode. Pulses default low so tx_valid/cmd_err last exactly one
    // cycle; everything else holds unless a frame says otherwise. A data
    // command without its address loaded only raises cmd_err.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_ok_d    = wr_ok_q;
        rd_ok_d    = rd_ok_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = payload_addr;
                    wr_ok_d   = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_ok_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr_d = wr_addr_q + 1'b1;
`endif
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = payload_addr;
                    rd_ok_d   = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_ok_q) begin
                        tx_data_d  = mem[rd_addr_q];
                        tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr_d = rd_addr_q + 1'b1;
`endif
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control/output registers. Reset wins over a frame in the same cycle,
    // which drops that frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_ok_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_ok_q    <= wr_ok_d;
            rd_ok_q    <= rd_ok_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Memory array is never cleared; the write is gated by reset so a frame
    // arriving together with reset is discarded. A read on the next cycle
    // sees the new value.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr_q] <= payload;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_ctrl
// Purpose : Directed self-checking bench for spi_ram_ctrl. Stimulus pushes the
//           expected response (read data or cmd_err, plus the cycle it must
//           appear in) into a queue; a monitor pops and compares whenever the
//           DUT raises tx_valid or cmd_err.
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cycle;
    } expect_t;

    logic    clk;
    logic    rst;
    int      cycleCount;
    int      checks;
    int      errors;
    bit      done;
    expect_t expQ [$];

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and cycle counter used to time-stamp responses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Drive one frame for one cycle; if a response is expected, queue it for
    // the cycle right after the sampling edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] payload,
                                 input bit expResp, input bit expErr,
                                 input logic [7:0] expData);
        expect_t e;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = {cmd, payload};
        if (expResp) begin
            e.isErr = expErr;
            e.data  = expData;
            e.cycle = cycleCount + 1;
            expQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 10'h000;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every DUT response against the queue head, flags
    // responses nobody expected and expectations whose cycle passed silently.
    always @(negedge clk) begin
        expect_t e;
        if (!done) begin
            if (expQ.size() > 0 && expQ[0].cycle < cycleCount) begin
                e = expQ.pop_front();
                checkOutput("missingResponse", 32'(e.cycle), 32'(cycleCount));
            end
            if (bus.tx_valid === 1'b1 && bus.cmd_err === 1'b1) begin
                checkOutput("txValidCmdErrExclusive", 32'd1, 32'd0);
            end else if (bus.tx_valid === 1'b1 || bus.cmd_err === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResponse",
                                {30'd0, bus.tx_valid, bus.cmd_err}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("responseKind", 32'(bus.cmd_err), 32'(e.isErr));
                    checkOutput("responseCycle", 32'(cycleCount), 32'(e.cycle));
                    if (!e.isErr) begin
                        checkOutput("txData", 32'(bus.tx_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        cycleCount   = 0;
        checks       = 0;
        errors       = 0;
        done         = 1'b0;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 10'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("resetTxData",  32'(bus.tx_data),  32'h00);
        checkOutput("resetTxValid", 32'(bus.tx_valid), 32'h0);
        checkOutput("resetCmdErr",  32'(bus.cmd_err),  32'h0);

        $display("[TB] test 1: write then read 0x12");
        applyStimulus(2'b00, 8'h12, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'hA5, 0, 0, 8'h00);
        applyStimulus(2'b10, 8'h12, 0, 0, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'hA5);
        idle(4);
        checkOutput("t1TxDataHold", 32'(bus.tx_data), 32'hA5);

        $display("[TB] test 2: data commands without addresses");
        doReset();
        checkOutput("t2TxDataAfterReset", 32'(bus.tx_data), 32'h00);
        applyStimulus(2'b01, 8'h33, 1, 1, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 1, 8'h00);
        idle(3);
        checkOutput("t2TxDataUnchanged", 32'(bus.tx_data), 32'h00);

        $display("[TB] test 3: reset collides with a frame");
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = {2'b00, 8'h40};
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        applyStimulus(2'b01, 8'h77, 1, 1, 8'h00);
        idle(3);

        $display("[TB] test 4: back-to-back frames at 0xFF");
        applyStimulus(2'b00, 8'hFF, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'h5A, 0, 0, 8'h00);
        applyStimulus(2'b10, 8'hFF, 0, 0, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h5A);
        idle(3);
        checkOutput("t4TxDataHold", 32'(bus.tx_data), 32'h5A);

        $display("[TB] test 5/6: repeated data commands");
        applyStimulus(2'b00, 8'hFF, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'h11, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'h22, 0, 0, 8'h00);
        applyStimulus(2'b10, 8'hFF, 0, 0, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h11);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h22);
`else
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h22);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h22);
`endif
        idle(3);

        $display("[TB] read immediately after write, same address");
        applyStimulus(2'b10, 8'h40, 0, 0, 8'h00);
        applyStimulus(2'b00, 8'h40, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'h9E, 0, 0, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h9E);
        idle(3);

        $display("[TB] address register independence");
        applyStimulus(2'b00, 8'h41, 0, 0, 8'h00);
        applyStimulus(2'b01, 8'h3C, 0, 0, 8'h00);
        applyStimulus(2'b10, 8'h40, 0, 0, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h9E);
        applyStimulus(2'b10, 8'h41, 0, 0, 8'h00);
        applyStimulus(2'b11, 8'h00, 1, 0, 8'h3C);
        idle(5);
        checkOutput("finalTxDataHold", 32'(bus.tx_data), 32'h3C);

        done = 1'b1;
        checkOutput("pendingResponses", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
